bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter RR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with m0 highest.
REQ-002 SHALL have port clock, input, 1 bit, the single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port m0_req / m1_req, input, 1 bit each, master requests a bus cycle this clock.
REQ-005 SHALL have port m0_lock / m1_lock, input, 1 bit each, master holds ownership after the current cycle.
REQ-006 SHALL have port m0_addr / m1_addr, input, 30 bits each, word address.
REQ-007 SHALL have port m0_data_w / m1_data_w, input, 32 bits each, write data.
REQ-008 SHALL have port m0_mask_w / m1_mask_w, input, 4 bits each, byte write enables; 0 means read.
REQ-009 SHALL have port m0_gnt / m1_gnt, output, 1 bit each, request accepted this clock.
REQ-010 SHALL have port m0_rvalid / m1_rvalid, output, 1 bit each, read data valid for that master.
REQ-011 SHALL have port m_data_r, output, 32 bits, read data shared by both masters and qualified by mN_rvalid.
REQ-012 SHALL have port bus_addr, output, 30 bits, to the single-port RAM.
REQ-013 SHALL have port bus_data_w, output, 32 bits, to the RAM.
REQ-014 SHALL have port bus_mask_w, output, 4 bits, to the RAM.
REQ-015 SHALL have port bus_data_r, input, 32 bits, from the RAM; registered with 1-cycle latency; undefined after a write cycle.

Function
REQ-016 SHALL decide the grant combinationally in cycle N; at most one mN_gnt is high; mN_gnt implies mN_req.
REQ-017 SHALL drive bus_addr, bus_data_w and bus_mask_w combinationally from the granted master in cycle N; the RAM samples them at the end-of-N posedge.
REQ-018 SHALL, when there is no grant, drive bus_mask_w = 0, bus_addr = 0 and bus_data_w = 0, so the cycle is a harmless read.
REQ-019 SHALL, for a granted read (mask = 0) in cycle N, assert exactly that master's rvalid for one cycle in N+1.
REQ-020 SHALL drive m_data_r = bus_data_r unconditionally.
REQ-021 SHALL generate no rvalid for a granted write; the grant alone is the completion.
REQ-022 SHALL hold state FREE or LOCKED(owner) plus a 1-bit last_owner pointer.
REQ-023 SHALL, in FREE with RR = 1 and both masters requesting, grant the master that is not last_owner.
REQ-024 SHALL, in FREE with RR = 0 and both masters requesting, always grant m0.
REQ-025 SHALL, in FREE with a single requester, grant that requester.
REQ-026 SHALL update last_owner to the granted master on every grant.
REQ-027 SHALL move from FREE to LOCKED(k) when mk is granted while mk_lock = 1.
REQ-028 SHALL, in LOCKED(k), grant only mk; the other master's request stalls with gnt = 0.
REQ-029 SHALL, in LOCKED(k), remain LOCKED while mk_lock = 1, whether or not mk_req is high; idle cycles drive per REQ-018.
REQ-030 SHALL return from LOCKED(k) to FREE at the clock where mk_lock = 0; if mk_req is high that same cycle, it is still granted to mk as the final locked access.
REQ-031 SHALL apply no lock timeout; bounding lock duration is the master's responsibility.
REQ-032 SHALL keep requests not granted in cycle N un-latched; the master holds req and payload until gnt.
REQ-033 SHALL let a read-after-write to the same address in back-to-back grants return the new data in the read's rvalid cycle.

Reset
REQ-034 SHALL, when reset is high at a posedge, set state = FREE, last_owner = 1 (so m0 wins the first tie) and both rvalid registers to 0.
REQ-035 SHALL force both mN_gnt = 0 and bus_mask_w = 0 combinationally while reset = 1.
REQ-036 SHALL, on reset mid-operation, drop any pending rvalid and any lock; rvalid is 0 in the cycle after reset.

Verification
REQ-037 SHALL cover: m0 reads 0x10 (RAM[0x10] = 0xDEADBEEF), m1 idle -> m0_gnt in N, m0_rvalid = 1 and m_data_r = 0xDEADBEEF in N+1, m1_rvalid = 0.
REQ-038 SHALL cover: RR = 1, both reading every cycle for 6 cycles after reset -> grants m0, m1, m0, m1, m0, m1, each rvalid one cycle after its grant.
REQ-039 SHALL cover: RR = 0, both requesting for 4 cycles -> m0 granted all 4 cycles, m1_gnt = 0 throughout.
REQ-040 SHALL cover: m1 write 0x00000055 mask 0xF to 0x20 with lock = 1, then read 0x20 with lock = 0, while m0 requests continuously -> m1 granted both cycles, m0 granted in the third cycle, m1_rvalid data = 0x00000055, no rvalid for the write.
REQ-041 SHALL cover: reset asserted in the cycle after an m0 read grant -> m0_rvalid = 0, then read 0x10 with RR = 1, both requesting, first grant after reset = m0.
REQ-042 SHALL cover: write with mask 0x2 of 0xAABBCCDD to 0x30 (old 0x11223344) -> a subsequent read returns 0x1122CC44; bus_mask_w = 0 on all idle cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of a single-port RAM with 1-cycle registered read data.
// Supports round-robin or fixed priority, plus bus locking for atomic sequences.
module bus_arbiter #(
  parameter int unsigned RR = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [29:0] m0_addr,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m0_data_w,
  input  logic [31:0] m1_data_w,
  input  logic [3:0]  m0_mask_w,
  input  logic [3:0]  m1_mask_w,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m_data_r,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_data_w,
  output logic [3:0]  bus_mask_w,
  input  logic [31:0] bus_data_r
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_owner, last_owner_next;
  logic   rvalid0, rvalid1;
  logic   gnt0, gnt1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FREE;
      last_owner <= 1'b1;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
      rvalid0    <= gnt0 && (m0_mask_w == '0);
      rvalid1    <= gnt1 && (m1_mask_w == '0);
    end
  end

  always_comb begin
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    state_next      = state;
    last_owner_next = last_owner;
    if (!reset) begin
      case (state)
        FREE: begin
          if (m0_req && m1_req) begin
            if (RR != 0 && last_owner == 1'b0) gnt1 = 1'b1;
            else                               gnt0 = 1'b1;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
          if (gnt0 && m0_lock)      state_next = LOCKED0;
          else if (gnt1 && m1_lock) state_next = LOCKED1;
        end
        // The owner's last access (lock low) is still granted while leaving LOCKED.
        LOCKED0: begin
          gnt0 = m0_req;
          if (!m0_lock) state_next = FREE;
        end
        LOCKED1: begin
          gnt1 = m1_req;
          if (!m1_lock) state_next = FREE;
        end
        default: state_next = FREE;
      endcase
      if (gnt0)      last_owner_next = 1'b0;
      else if (gnt1) last_owner_next = 1'b1;
    end
  end

  always_comb begin
    bus_addr   = '0;
    bus_data_w = '0;
    bus_mask_w = '0;
    if (gnt0) begin
      bus_addr   = m0_addr;
      bus_data_w = m0_data_w;
      bus_mask_w = m0_mask_w;
    end else if (gnt1) begin
      bus_addr   = m1_addr;
      bus_data_w = m1_data_w;
      bus_mask_w = m1_mask_w;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0;
  assign m1_rvalid = rvalid1;
  assign m_data_r  = bus_data_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: RAM model, per-scenario tasks, rvalid/data scoreboard.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_lock, m1_lock;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_data_w, m1_data_w;
  logic [3:0]  m0_mask_w, m1_mask_w;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m_data_r, bus_data_w, bus_data_r;
  logic [29:0] bus_addr;
  logic [3:0]  bus_mask_w;

  logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid;
  logic [31:0] fp_m_data_r, fp_bus_data_w;
  logic [29:0] fp_bus_addr;
  logic [3:0]  fp_bus_mask_w;

  logic        preload;
  logic [31:0] ram [0:255];

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  bus_arbiter #(.RR(1)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_data_w(m0_data_w), .m1_data_w(m1_data_w),
    .m0_mask_w(m0_mask_w), .m1_mask_w(m1_mask_w),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m_data_r(m_data_r), .bus_addr(bus_addr),
    .bus_data_w(bus_data_w), .bus_mask_w(bus_mask_w),
    .bus_data_r(bus_data_r)
  );

  bus_arbiter #(.RR(0)) dut_fp (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_data_w(m0_data_w), .m1_data_w(m1_data_w),
    .m0_mask_w(m0_mask_w), .m1_mask_w(m1_mask_w),
    .m0_gnt(fp_m0_gnt), .m1_gnt(fp_m1_gnt),
    .m0_rvalid(fp_m0_rvalid), .m1_rvalid(fp_m1_rvalid),
    .m_data_r(fp_m_data_r), .bus_addr(fp_bus_addr),
    .bus_data_w(fp_bus_data_w), .bus_mask_w(fp_bus_mask_w),
    .bus_data_r(32'h0)
  );

  // Single-port RAM: byte-masked write, registered read.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[8'h10] <= 32'hDEADBEEF;
      ram[8'h30] <= 32'h11223344;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus_mask_w[b]) ram[bus_addr[7:0]][b*8 +: 8] <= bus_data_w[b*8 +: 8];
    end
    bus_data_r <= ram[bus_addr[7:0]];
  end

  // Each entry pushed in cycle N describes rvalid/data visible in cycle N+1.
  always begin
    @(posedge clock);
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (m0_rvalid !== mon_e.v0 || m1_rvalid !== mon_e.v1) begin
        n_fail++;
        $display("FAIL rvalid @%0t: got m0=%b m1=%b expected m0=%b m1=%b",
                 $time, m0_rvalid, m1_rvalid, mon_e.v0, mon_e.v1);
      end
      if (mon_e.v0 || mon_e.v1) begin
        n_checks++;
        if (m_data_r !== mon_e.data) begin
          n_fail++;
          $display("FAIL rdata @%0t: got %h expected %h", $time, m_data_r, mon_e.data);
        end
      end
    end
  end

  task automatic drive0(input logic req, input logic lock, input logic [29:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
    m0_req = req; m0_lock = lock; m0_addr = addr; m0_data_w = data; m0_mask_w = mask;
  endtask

  task automatic drive1(input logic req, input logic lock, input logic [29:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
    m1_req = req; m1_lock = lock; m1_addr = addr; m1_data_w = data; m1_mask_w = mask;
  endtask

  task automatic idle_all();
    drive0(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    drive1(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
  endtask

  task automatic push_exp(input logic v0, input logic v1, input logic [31:0] data);
    exp_t e;
    e.v0 = v0; e.v1 = v1; e.data = data;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive0(1'b1, 1'b1, 30'h20, 32'h1, 4'hF);
    drive1(1'b1, 1'b0, 30'h30, 32'h2, 4'h3);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || bus_mask_w !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_force: got gnt=%b%b mask=%h expected gnt=00 mask=0", m0_gnt, m1_gnt, bus_mask_w);
    end
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    idle_all();
    #1;
    n_checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || bus_mask_w !== 4'h0 || bus_addr !== 30'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt=%b%b mask=%h addr=%h expected 00/0/0", m0_gnt, m1_gnt, bus_mask_w, bus_addr);
    end
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
  endtask

  task automatic test_single_read();
    drive0(1'b1, 1'b0, 30'h10, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || bus_addr !== 30'h10 || bus_mask_w !== 4'h0) begin
      n_fail++;
      $display("FAIL single_read: got gnt=%b%b addr=%h mask=%h expected 10/10/0", m0_gnt, m1_gnt, bus_addr, bus_mask_w);
    end
    push_exp(1'b1, 1'b0, 32'hDEADBEEF);
    @(negedge clock);
    idle_all();
    #1;
    n_checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || bus_mask_w !== 4'h0) begin
      n_fail++;
      $display("FAIL single_idle: got gnt=%b%b mask=%h expected 00/0", m0_gnt, m1_gnt, bus_mask_w);
    end
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
  endtask

  task automatic test_round_robin();
    logic e0;
    reset = 1'b1;
    idle_all();
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive0(1'b1, 1'b0, 30'h10, 32'h0, 4'h0);
      drive1(1'b1, 1'b0, 30'h30, 32'h0, 4'h0);
      e0 = (i % 2 == 0);
      #1;
      n_checks++;
      if (m0_gnt !== e0 || m1_gnt !== !e0 || bus_addr !== (e0 ? 30'h10 : 30'h30)) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d]: got gnt=%b%b addr=%h expected gnt=%b%b", i, m0_gnt, m1_gnt, bus_addr, e0, !e0);
      end
      push_exp(e0, !e0, e0 ? 32'hDEADBEEF : 32'h11223344);
      @(negedge clock);
    end
    idle_all();
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
  endtask

  task automatic test_fixed_priority();
    reset = 1'b1;
    idle_all();
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b0, 30'h10, 32'h0, 4'h0);
      drive1(1'b1, 1'b0, 30'h30, 32'h0, 4'h0);
      #1;
      n_checks++;
      if (fp_m0_gnt !== 1'b1 || fp_m1_gnt !== 1'b0 || fp_bus_addr !== 30'h10) begin
        n_fail++;
        $display("FAIL fp_gnt[%0d]: got gnt=%b%b addr=%h expected gnt=10 addr=10", i, fp_m0_gnt, fp_m1_gnt, fp_bus_addr);
      end
      @(negedge clock);
    end
    idle_all();
    @(negedge clock);
  endtask

  task automatic test_lock();
    // Prep: m0 alone so m1 wins the following tie.
    drive0(1'b1, 1'b0, 30'h10, 32'h0, 4'h0);
    drive1(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_prep: got gnt=%b%b expected 10", m0_gnt, m1_gnt);
    end
    push_exp(1'b1, 1'b0, 32'hDEADBEEF);
    @(negedge clock);
    drive1(1'b1, 1'b1, 30'h20, 32'h00000055, 4'hF);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1 || bus_addr !== 30'h20 ||
        bus_data_w !== 32'h00000055 || bus_mask_w !== 4'hF) begin
      n_fail++;
      $display("FAIL lock_write: got gnt=%b%b addr=%h data=%h mask=%h expected 01/20/00000055/f",
               m0_gnt, m1_gnt, bus_addr, bus_data_w, bus_mask_w);
    end
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
    drive1(1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1 || bus_addr !== 30'h20 || bus_mask_w !== 4'h0) begin
      n_fail++;
      $display("FAIL lock_read: got gnt=%b%b addr=%h mask=%h expected 01/20/0", m0_gnt, m1_gnt, bus_addr, bus_mask_w);
    end
    push_exp(1'b0, 1'b1, 32'h00000055);
    @(negedge clock);
    drive1(1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_release: got gnt=%b%b expected 10", m0_gnt, m1_gnt);
    end
    push_exp(1'b1, 1'b0, 32'hDEADBEEF);
    @(negedge clock);
    // Locked owner idles: m0 must stall, including the cycle lock drops.
    drive1(1'b1, 1'b1, 30'h30, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_take: got gnt=%b%b expected 01", m0_gnt, m1_gnt);
    end
    push_exp(1'b0, 1'b1, 32'h11223344);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      drive1(1'b0, (i == 0), 30'h0, 32'h0, 4'h0);
      #1;
      n_checks++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || bus_mask_w !== 4'h0 || bus_addr !== 30'h0) begin
        n_fail++;
        $display("FAIL lock_idle[%0d]: got gnt=%b%b mask=%h addr=%h expected 00/0/0", i, m0_gnt, m1_gnt, bus_mask_w, bus_addr);
      end
      push_exp(1'b0, 1'b0, 32'h0);
      @(negedge clock);
    end
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_free: got gnt=%b%b expected 10", m0_gnt, m1_gnt);
    end
    push_exp(1'b1, 1'b0, 32'hDEADBEEF);
    @(negedge clock);
    idle_all();
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 1'b0, 30'h10, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pre: got gnt=%b%b expected 10", m0_gnt, m1_gnt);
    end
    push_exp(1'b1, 1'b0, 32'hDEADBEEF);
    @(negedge clock);
    reset = 1'b1;
    drive1(1'b1, 1'b0, 30'h30, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || bus_mask_w !== 4'h0) begin
      n_fail++;
      $display("FAIL rstmid_force: got gnt=%b%b mask=%h expected 00/0", m0_gnt, m1_gnt, bus_mask_w);
    end
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (m0_gnt !== (i == 0) || m1_gnt !== (i == 1)) begin
        n_fail++;
        $display("FAIL rstmid_tie[%0d]: got gnt=%b%b expected %b%b", i, m0_gnt, m1_gnt, (i == 0), (i == 1));
      end
      push_exp((i == 0), (i == 1), (i == 0) ? 32'hDEADBEEF : 32'h11223344);
      @(negedge clock);
    end
    idle_all();
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
  endtask

  task automatic test_partial_write();
    drive0(1'b1, 1'b0, 30'h30, 32'hAABBCCDD, 4'h2);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || bus_addr !== 30'h30 || bus_data_w !== 32'hAABBCCDD || bus_mask_w !== 4'h2) begin
      n_fail++;
      $display("FAIL pw_write: got gnt=%b addr=%h data=%h mask=%h expected 1/30/aabbccdd/2",
               m0_gnt, bus_addr, bus_data_w, bus_mask_w);
    end
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
    idle_all();
    #1;
    n_checks++;
    if (m0_gnt !== 1'b0 || bus_mask_w !== 4'h0 || bus_addr !== 30'h0 || bus_data_w !== 32'h0) begin
      n_fail++;
      $display("FAIL pw_idle: got gnt=%b mask=%h addr=%h data=%h expected 0/0/0/0", m0_gnt, bus_mask_w, bus_addr, bus_data_w);
    end
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
    drive0(1'b1, 1'b0, 30'h30, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || bus_mask_w !== 4'h0) begin
      n_fail++;
      $display("FAIL pw_read: got gnt=%b mask=%h expected 1/0", m0_gnt, bus_mask_w);
    end
    push_exp(1'b1, 1'b0, 32'h1122CC44);
    @(negedge clock);
    idle_all();
    push_exp(1'b0, 1'b0, 32'h0);
    @(negedge clock);
  endtask

  initial begin
    reset   = 1'b1;
    preload = 1'b1;
    idle_all();
    repeat (2) @(negedge clock);
    preload = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_lock();
    test_reset_mid();
    test_partial_write();
    @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
